// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Writeback arbiter that drives the register-file write port.
//            It merges the single-cycle ALU path with a FIFO-buffered
//            load-return path. The ALU has priority, but an anti-starvation
//            counter limits how long loads can be held off. A pending-write
//            lookup is provided for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_stall,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_reg,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_reg,
  output logic [DATA_W-1:0]          wr_data,
  output logic [$clog2(Q_DEPTH):0]   q_count,
  output logic                       q_full,
  output logic                       q_empty,
  input  logic [ADDR_W-1:0]          chk_reg,
  output logic                       chk_pending
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] slot_reg  [Q_DEPTH];
  logic [DATA_W-1:0] slot_data [Q_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ST_W-1:0]   starve_cnt;

  logic starve_hit;
  logic q_win;
  logic alu_win;
  logic push;
  logic pop;

  assign q_count  = count;
  assign q_full   = (count == CNT_W'(Q_DEPTH));
  assign q_empty  = (count == '0);
  // Readiness looks only at current occupancy, so a same-cycle pop never frees a slot early.
  assign ld_ready = !q_full;

  assign starve_hit = (starve_cnt == ST_W'(STARVE_MAX));
  // The queue can only win with entries already stored, so there is no push-to-pop bypass.
  assign q_win      = !q_empty && (!alu_valid || starve_hit);
  assign alu_win    = alu_valid && !q_win;
  assign alu_stall  = alu_valid && q_win;
  assign pop        = q_win;
  // A register-0 load completes its handshake but is discarded.
  assign push       = ld_valid && ld_ready && (ld_reg != '0);

  // Payload storage: stale slots are harmless because validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_reg[wr_ptr]  <= ld_reg;
      slot_data[wr_ptr] <= ld_data;
    end
  end

  // Circular FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Anti-starvation counter: count consecutive ALU wins while loads wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (q_empty || q_win) begin
      starve_cnt <= '0;
    end else if (alu_win && !starve_hit) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  // Registered write port: latch the winner, and hold reg/data when nobody writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= q_win || (alu_win && (alu_reg != '0));
      if (q_win) begin
        wr_reg  <= slot_reg[rd_ptr];
        wr_data <= slot_data[rd_ptr];
      end else if (alu_win && (alu_reg != '0)) begin
        wr_reg  <= alu_reg;
        wr_data <= alu_data;
      end
    end
  end

  // Hazard lookup: OR of reg matches over occupied slots, including the one being popped.
  always_comb begin
    logic [PTR_W-1:0] offset;
    chk_pending = 1'b0;
    offset      = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if (({1'b0, offset} < count) && (slot_reg[i] == chk_reg)) begin
        chk_pending = 1'b1;
      end
    end
    if (chk_reg == '0) begin
      chk_pending = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Self-checking bench for regfile_wb_arbiter. It applies a directed
//            vector table, then hand-written sequences for starvation,
//            hazard lookup and asynchronous reset, then random traffic
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int Q_DEPTH    = 4;
  localparam int STARVE_MAX = 3;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        q_count;
  logic              q_full;
  logic              q_empty;
  logic [ADDR_W-1:0] chk_reg;
  logic              chk_pending;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .Q_DEPTH(Q_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .q_count(q_count), .q_full(q_full), .q_empty(q_empty),
    .chk_reg(chk_reg), .chk_pending(chk_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // ---------------- reference model: queue of pending loads ----------------
  typedef struct packed { logic [ADDR_W-1:0] r; logic [DATA_W-1:0] d; } ent_t;
  ent_t              mq[$];
  int                m_starve;
  logic              m_wen;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_wen    = 1'b0;
    m_wreg   = '0;
    m_wdata  = '0;
  endtask

  function automatic logic m_qwin();
    return (mq.size() > 0) && (!alu_valid || (m_starve == STARVE_MAX));
  endfunction

  function automatic logic m_pend();
    logic p = 1'b0;
    foreach (mq[i]) if (chk_reg != 0 && mq[i].r == chk_reg) p = 1'b1;
    return p;
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    bit   nonempty = (mq.size() > 0);
    bit   can_push = (mq.size() < Q_DEPTH);
    bit   qw       = m_qwin();
    ent_t e;
    if (qw) begin
      e        = mq.pop_front();
      m_wen    = 1'b1;
      m_wreg   = e.r;
      m_wdata  = e.d;
      m_starve = 0;
    end else if (alu_valid) begin
      m_wen = (alu_reg != 0);
      if (alu_reg != 0) begin
        m_wreg  = alu_reg;
        m_wdata = alu_data;
      end
      m_starve = nonempty ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
    end else begin
      m_wen    = 1'b0;
      m_starve = 0;
    end
    if (ld_valid && can_push && ld_reg != 0) begin
      e.r = ld_reg;
      e.d = ld_data;
      mq.push_back(e);
    end
  endtask

  logic last_stall;
  logic last_pend;

  // One model-checked cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic cycle(input logic av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic lv, input logic [ADDR_W-1:0] lr, input logic [DATA_W-1:0] ld,
                       input logic [ADDR_W-1:0] ck);
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid = lv;  ld_reg = lr;  ld_data = ld;
    chk_reg = ck;
    #1;
    last_stall = alu_stall;
    last_pend  = chk_pending;
    chk("m_alu_stall",   checks, 32'(alu_stall),   32'(m_qwin() && av));
    chk("m_ld_ready",    checks, 32'(ld_ready),    32'(mq.size() < Q_DEPTH));
    chk("m_chk_pending", checks, 32'(chk_pending), 32'(m_pend()));
    @(posedge clk);
    model_step();
    #1;
    chk("m_wr_en",   checks, 32'(wr_en),   32'(m_wen));
    chk("m_wr_reg",  checks, 32'(wr_reg),  32'(m_wreg));
    chk("m_wr_data", checks, 32'(wr_data), 32'(m_wdata));
    chk("m_q_count", checks, 32'(q_count), 32'(mq.size()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic av; logic [ADDR_W-1:0] ar; logic [DATA_W-1:0] ad;
    logic lv; logic [ADDR_W-1:0] lr; logic [DATA_W-1:0] ld;
    logic [ADDR_W-1:0] ck;
    logic e_stall; logic e_ready; logic e_pend;
    logic e_wen; logic [ADDR_W-1:0] e_wreg; logic [DATA_W-1:0] e_wdata; logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic av, logic [3:0] ar, logic [15:0] ad,
                              logic lv, logic [3:0] lr, logic [15:0] ld, logic [3:0] ck,
                              logic es, logic er, logic ep,
                              logic ew, logic [3:0] wr, logic [15:0] wd, logic [2:0] cnt);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld; v.ck = ck;
    v.e_stall = es; v.e_ready = er; v.e_pend = ep;
    v.e_wen = ew; v.e_wreg = wr; v.e_wdata = wd; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    // ALU write with one-cycle latency, then idle.
    tbl[0]  = mk(1, 5,  16'h1234, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 5,  16'h1234, 0);
    tbl[1]  = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 5,  16'h1234, 0);
    // Fill the FIFO while the ALU keeps winning; the 4th ALU-held cycle triggers a stall.
    tbl[2]  = mk(1, 6,  16'h0006, 1, 1, 16'hA001, 1, 0, 1, 0, 1, 6,  16'h0006, 1);
    tbl[3]  = mk(1, 8,  16'h0008, 1, 2, 16'hA002, 2, 0, 1, 0, 1, 8,  16'h0008, 2);
    tbl[4]  = mk(1, 10, 16'h000A, 1, 3, 16'hA003, 1, 0, 1, 1, 1, 10, 16'h000A, 3);
    tbl[5]  = mk(1, 11, 16'h000B, 1, 4, 16'hA004, 3, 0, 1, 1, 1, 11, 16'h000B, 4);
    // Full: load 5 refused even though a pop happens this cycle.
    tbl[6]  = mk(1, 12, 16'h000C, 1, 5, 16'hA005, 4, 1, 0, 1, 1, 1,  16'hA001, 3);
    // Drain in FIFO order with the ALU idle.
    tbl[7]  = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 5, 0, 1, 0, 1, 2,  16'hA002, 2);
    tbl[8]  = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 4, 0, 1, 1, 1, 3,  16'hA003, 1);
    tbl[9]  = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 4, 0, 1, 1, 1, 4,  16'hA004, 0);
    tbl[10] = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 4, 0, 1, 0, 0, 4,  16'hA004, 0);
    // Register 0 writes from both sides are dropped.
    tbl[11] = mk(1, 0,  16'hDEAD, 1, 0, 16'hBEEF, 0, 0, 1, 0, 0, 4,  16'hA004, 0);
    tbl[12] = mk(0, 0,  16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 4,  16'hA004, 0);
  end

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_reg = '0;  ld_data = '0;
    chk_reg = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",     0, 32'(wr_en),     32'(0));
    chk("rst_wr_reg",    0, 32'(wr_reg),    32'(0));
    chk("rst_wr_data",   0, 32'(wr_data),   32'(0));
    chk("rst_q_count",   0, 32'(q_count),   32'(0));
    chk("rst_q_empty",   0, 32'(q_empty),   32'(1));
    chk("rst_q_full",    0, 32'(q_full),    32'(0));
    chk("rst_ld_ready",  0, 32'(ld_ready),  32'(1));
    chk("rst_alu_stall", 0, 32'(alu_stall), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
      ld_valid  = tbl[i].lv; ld_reg  = tbl[i].lr; ld_data  = tbl[i].ld;
      chk_reg   = tbl[i].ck;
      #1;
      chk("tbl_alu_stall",   i, 32'(alu_stall),   32'(tbl[i].e_stall));
      chk("tbl_ld_ready",    i, 32'(ld_ready),    32'(tbl[i].e_ready));
      chk("tbl_chk_pending", i, 32'(chk_pending), 32'(tbl[i].e_pend));
      @(posedge clk);
      model_step();
      #1;
      chk("tbl_wr_en",   i, 32'(wr_en),   32'(tbl[i].e_wen));
      chk("tbl_wr_reg",  i, 32'(wr_reg),  32'(tbl[i].e_wreg));
      chk("tbl_wr_data", i, 32'(wr_data), 32'(tbl[i].e_wdata));
      chk("tbl_q_count", i, 32'(q_count), 32'(tbl[i].e_cnt));
      chk("tbl_q_full",  i, 32'(q_full),  32'(tbl[i].e_cnt == 3'd4));
      chk("tbl_q_empty", i, 32'(q_empty), 32'(tbl[i].e_cnt == 3'd0));
    end

    // ---- starvation bound: reg 7 waits behind exactly 3 ALU wins ----
    cycle(1, 13, 16'h0D0D, 1, 7, 16'h7777, 7);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 13, 16'(16'h1300 + k), 0, 0, 16'h0000, 7);
      if (k < 3) begin
        chk("starve_no_stall", k, 32'(last_stall), 32'(0));
        chk("starve_alu_reg",  k, 32'(wr_reg),     32'(13));
      end else begin
        chk("starve_stall",    k, 32'(last_stall), 32'(1));
        chk("starve_ld_reg",   k, 32'(wr_reg),     32'(7));
        chk("starve_ld_data",  k, 32'(wr_data),    32'(16'h7777));
      end
    end
    cycle(1, 13, 16'h13FF, 0, 0, 16'h0000, 0);
    chk("starve_after_alu", 0, 32'(last_stall), 32'(0));

    // ---- hazard lookup over regs 3 and 9 ----
    cycle(1, 0, 16'h0000, 1, 3, 16'h0333, 9);
    cycle(1, 0, 16'h0000, 1, 9, 16'h0999, 9);
    chk("pend_not_yet", 0, 32'(last_pend), 32'(0));
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000, 9);
    chk("pend_reg9",    0, 32'(last_pend), 32'(1));
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    chk("pend_reg0",    0, 32'(last_pend), 32'(0));
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 9);
    chk("pend_pop3",    0, 32'(last_pend), 32'(1));
    chk("pend_pop3_wr", 0, 32'(wr_reg),    32'(3));
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 9);
    chk("pend_popping9", 0, 32'(last_pend), 32'(1));
    chk("pend_pop9_wr",  0, 32'(wr_reg),    32'(9));
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 9);
    chk("pend_drained", 0, 32'(last_pend), 32'(0));

    // ---- asynchronous reset with 3 queued entries and a live write ----
    cycle(1, 14, 16'h0E0E, 1, 1, 16'hB001, 0);
    cycle(1, 14, 16'h0E0E, 1, 2, 16'hB002, 0);
    cycle(1, 14, 16'h0E0E, 1, 3, 16'hB003, 0);
    chk("arst_pre_count", 0, 32'(q_count), 32'(3));
    chk("arst_pre_wr_en", 0, 32'(wr_en),   32'(1));
    #2;
    rst = 1'b0;
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    chk("arst_wr_en",    0, 32'(wr_en),    32'(0));
    chk("arst_wr_reg",   0, 32'(wr_reg),   32'(0));
    chk("arst_wr_data",  0, 32'(wr_data),  32'(0));
    chk("arst_q_count",  0, 32'(q_count),  32'(0));
    chk("arst_q_empty",  0, 32'(q_empty),  32'(1));
    chk("arst_ld_ready", 0, 32'(ld_ready), 32'(1));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 1);
      chk("arst_no_stale", k, 32'(wr_en), 32'(0));
    end

    // ---- random traffic against the reference model ----
    for (int n = 0; n < 500; n++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
            4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
